button_debounce: RTL and testbench

Multi-channel, parametrised successor to the single-flop button-to-LED path on the XO3D board. Each channel synchronises a raw push-button input and debounces it with a per-channel stability counter. It produces a clean level, single-cycle press/release strobes, and an LED drive in follow or toggle mode. It sits directly behind the button input pads and feeds the LEDs and the downstream ws2812 control logic.

---
 rtl/button_pkg.sv | 12 +
 rtl/button_debounce_ch.sv | 56 +++++
 rtl/button_debounce.sv | 43 ++++
 tb/tb_button_debounce.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared LED mode constants and counter sizing for the button debouncer
package button_pkg;

    localparam int LED_FOLLOW = 0;
    localparam int LED_TOGGLE = 1;

    // width of the stability counter; DEBOUNCE_CYCLES >= 2 keeps this at least 1
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one channel - synchroniser, stability counter, strobes and LED drive
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 0,
    parameter int LED_MODE        = LED_FOLLOW,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic state,
    output logic pressed,
    output logic released,
    output logic led
);

    localparam logic             IDLE     = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s, accept;

    // synchroniser chain resets to the idle pad level so reset release never looks like an edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= {SYNC_STAGES{IDLE}};
        else        sync <= {sync[SYNC_STAGES-2:0], button};

    assign s = sync[SYNC_STAGES-1] ^ IDLE;

    // accept a change once the sample has differed from state for DEBOUNCE_CYCLES cycles in a row
    always_comb begin
        accept  = (s != state) && (cnt == CNT_LAST);
        cnt_nxt = (s == state || accept) ? '0 : cnt + 1'b1;
    end

    // debounced level, strobes and LED drive all update on the accepting edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt      <= '0;
            state    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
            led      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            state    <= accept ? s : state;
            pressed  <= accept && s;
            released <= accept && !s;
            led      <= (LED_MODE == LED_TOGGLE) ? led ^ (accept && s) : (accept ? s : state);
        end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: N independent push-button channels, each synchronised and debounced
module button_debounce
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 0,
    parameter int LED_MODE        = LED_FOLLOW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] state,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] released,
    output logic [N_BUTTONS-1:0] led
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    genvar i;
    generate
        for (i = 0; i < N_BUTTONS; i++) begin : g_ch
            button_debounce_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .ACTIVE_LOW     (ACTIVE_LOW),
                .LED_MODE       (LED_MODE),
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .button  (button[i]),
                .state   (state[i]),
                .pressed (pressed[i]),
                .released(released[i]),
                .led     (led[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench over follow, toggle and active-low instances
module tb_button_debounce;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] bt [3];
    logic [2:0] st [3];
    logic [2:0] pr [3];
    logic [2:0] rl [3];
    logic [2:0] ld [3];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         d;
        int         cyc;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] s;
        logic [2:0] l;
    } ev_t;

    ev_t exp_q [$];

    button_debounce #(.N_BUTTONS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0), .LED_MODE(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .button(bt[0]), .state(st[0]), .pressed(pr[0]), .released(rl[0]), .led(ld[0]));
    button_debounce #(.N_BUTTONS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0), .LED_MODE(1)) dut_t (
        .clk(clk), .rst_n(rst_n), .button(bt[1]), .state(st[1]), .pressed(pr[1]), .released(rl[1]), .led(ld[1]));
    button_debounce #(.N_BUTTONS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .LED_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .button(bt[2]), .state(st[2]), .pressed(pr[2]), .released(rl[2]), .led(ld[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // strobe expected dc cycles after the drive that happens right after this negedge
    task automatic push_ev(input int d, input int dc, input logic [2:0] p, input logic [2:0] r,
                           input logic [2:0] s, input logic [2:0] l);
        ev_t e;
        e = '{d: d, cyc: cyc + dc, p: p, r: r, s: s, l: l};
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s state dut%0d", tag, d), int'(st[d]), 0);
        chk($sformatf("%s pressed dut%0d", tag, d), int'(pr[d]), 0);
        chk($sformatf("%s released dut%0d", tag, d), int'(rl[d]), 0);
        chk($sformatf("%s led dut%0d", tag, d), int'(ld[d]), 0);
    endtask

    // monitor: every strobe pops the next expected event; an overdue event counts as missing
    always @(negedge clk) begin
        ev_t e;
        for (int d = 0; d < 3; d++) begin
            if (exp_q.size() > 0 && exp_q[0].d == d && cyc > exp_q[0].cyc) begin
                chk($sformatf("missing strobe dut%0d", d), cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (pr[d] != 3'b000 || rl[d] != 3'b000) begin
                if (exp_q.size() == 0 || exp_q[0].d != d) begin
                    chk($sformatf("unexpected strobe dut%0d", d), int'({pr[d], rl[d]}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("strobe cycle dut%0d", d), cyc, e.cyc);
                    chk($sformatf("pressed dut%0d", d), int'(pr[d]), int'(e.p));
                    chk($sformatf("released dut%0d", d), int'(rl[d]), int'(e.r));
                    chk($sformatf("state dut%0d", d), int'(st[d]), int'(e.s));
                    chk($sformatf("led dut%0d", d), int'(ld[d]), int'(e.l));
                end
            end
        end
    end

    initial begin
        bt[0] = 3'b000;
        bt[1] = 3'b000;
        bt[2] = 3'b111;
        wait_cyc(3);
        #1;
        for (int d = 0; d < 3; d++) chk_zero(d, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        // idle pads (including active-low ones held at 1) must produce nothing
        wait_cyc(20);
        for (int d = 0; d < 3; d++) chk($sformatf("idle state dut%0d", d), int'(st[d]), 0);
        chk("idle led dut2", int'(ld[2]), 0);
        // clean press and release on channel 0
        bt[0] = 3'b001;
        push_ev(0, 6, 3'b001, 3'b000, 3'b001, 3'b001);
        wait_cyc(12);
        bt[0] = 3'b000;
        push_ev(0, 6, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_cyc(12);
        // bounce on channel 1: 3 high, 1 low, 3 high
        bt[0] = 3'b010;
        wait_cyc(3);
        bt[0] = 3'b000;
        wait_cyc(1);
        bt[0] = 3'b010;
        wait_cyc(3);
        bt[0] = 3'b000;
        wait_cyc(12);
        chk("bounce state dut0", int'(st[0]), 0);
        // channels 0 and 2 together, channel 1 untouched
        bt[0] = 3'b101;
        push_ev(0, 6, 3'b101, 3'b000, 3'b101, 3'b101);
        wait_cyc(12);
        bt[0] = 3'b000;
        push_ev(0, 6, 3'b000, 3'b101, 3'b000, 3'b000);
        wait_cyc(12);
        // toggle mode: LED flips only on presses
        bt[1] = 3'b001;
        push_ev(1, 6, 3'b001, 3'b000, 3'b001, 3'b001);
        wait_cyc(10);
        bt[1] = 3'b000;
        push_ev(1, 6, 3'b000, 3'b001, 3'b000, 3'b001);
        wait_cyc(10);
        bt[1] = 3'b001;
        push_ev(1, 6, 3'b001, 3'b000, 3'b001, 3'b000);
        wait_cyc(10);
        bt[1] = 3'b000;
        push_ev(1, 6, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_cyc(10);
        // reset mid-count: partial count discarded, full latency from release
        bt[0] = 3'b001;
        wait_cyc(3);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "midreset");
        @(negedge clk);
        rst_n = 1'b1;
        push_ev(0, 6, 3'b001, 3'b000, 3'b001, 3'b001);
        wait_cyc(10);
        bt[0] = 3'b000;
        push_ev(0, 6, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_cyc(10);
        // active-low pad on channel 2
        bt[2] = 3'b011;
        push_ev(2, 6, 3'b100, 3'b000, 3'b100, 3'b100);
        wait_cyc(10);
        bt[2] = 3'b111;
        push_ev(2, 6, 3'b000, 3'b100, 3'b000, 3'b000);
        wait_cyc(10);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        chk("events left over", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
